serial_add_46: RTL and testbench

Bit-serial adder: the addition counterpart of the team's half-subtractor cells. It takes two WIDTH-bit operands on a start strobe and adds them LSB-first, one bit per clock, through a single full-adder slice with a registered carry. It presents the sum and carry-out with a one-cycle done pulse. It is the area-minimal arithmetic primitive for control paths where latency is acceptable.

---
 rtl/serial_add_46.sv | 102 ++++++++++
 tb/tb_serial_add_46.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_46.sv
// Bit-serial adder: one full-adder slice, LSB-first, registered carry.
// Optional subtract mode enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_46 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic             c;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             sub_q;
    logic             sub_in;
    logic             bb;
    logic             s;
    logic             cn;
    logic             last;
    logic             load;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    always_comb begin
        bb      = b_sr[0] ^ sub_q;
        s       = a_sr[0] ^ bb ^ c;
        cn      = (a_sr[0] & bb) | (a_sr[0] & c) | (bb & c);
        last    = (cnt == CW'(WIDTH - 1));
        load    = start && (state != RUN);
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    state_n = start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            c     <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            sub_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n == RUN);
            done  <= (state_n == DONE);
            if (load) begin
                a_sr  <= a;
                b_sr  <= b;
                sub_q <= sub_in;
                cnt   <= '0;
                c     <= sub_in;
            end else if (state == RUN) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                r_sr <= {s, r_sr[WIDTH-1:1]};
                cnt  <= cnt + CW'(1);
                c    <= cn;
                // Last edge: the final sum bit joins the bits already shifted in
                if (last) begin
                    sum  <= {s, r_sr[WIDTH-1:1]};
                    cout <= cn ^ sub_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_add_46.sv
// Scoreboard bench for serial_add_46.
// Expected results are queued at acceptance and checked on done.
module tb_serial_add_46;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       sub_i = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;
    int cyc = 0;
    int busy_run = 0;
    int last_done = -1;
    bit b2b = 1'b0;
    logic [8:0] last_res = '0;
    logic [8:0] q[$];

    serial_add_46 #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub  (sub_i),
`endif
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] x,
                                         input logic [7:0] y,
                                         input logic s);
        logic [8:0] r;
        if (s) r = {x < y, x - y};
        else   r = {1'b0, x} + {1'b0, y};
        return r;
    endfunction

    always @(negedge clk) begin
        if (busy) begin
            busy_run++;
            chk("hold", {cout, sum}, last_res);
        end
        if (done) begin
            n_done++;
            chk("busy_len", busy_run, 8);
            busy_run = 0;
            if (b2b && last_done >= 0) chk("interval", cyc - last_done, 9);
            last_done = cyc;
            if (q.size() == 0) begin
                chk("unexp_done", 1, 0);
            end else begin
                chk("result", {cout, sum}, q.pop_front());
            end
            last_res = {cout, sum};
        end
    end

    task automatic op(input logic [7:0] x, input logic [7:0] y,
                      input logic s);
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        a = x;
        b = y;
        sub_i = s;
        q.push_back(model(x, y, s));
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        sub_i = ~s;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int d0;
        int acc;
        logic s;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out", {cout, sum}, 0);
        rst = 1'b0;

        op(8'h3C, 8'h0F, 1'b0);
        wait_idle();
        chk("res_3c0f", {cout, sum}, 9'h04B);
        op(8'hFF, 8'h01, 1'b0);
        wait_idle();
        chk("res_ff01", {cout, sum}, 9'h100);
        d0 = n_done;
        op(8'h00, 8'h00, 1'b0);
        wait_idle();
        chk("res_0000", {cout, sum}, 9'h000);
        chk("done_again", n_done, d0 + 1);

        d0 = n_done;
        op(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("ign_count", n_done, d0 + 1);
        chk("ign_sum", {cout, sum}, 9'h030);

        d0 = n_done;
        op(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        busy_run = 0;
        last_res = '0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_out", {cout, sum}, 0);
        repeat (15) @(negedge clk);
        chk("abort_nodone", n_done, d0);
        op(8'h01, 8'h01, 1'b0);
        wait_idle();
        chk("res_0101", {cout, sum}, 9'h002);

        b2b = 1'b1;
        last_done = -1;
        d0 = n_done;
        acc = 0;
        while (acc < 6) begin
            @(negedge clk);
            start = 1'b1;
            a = $urandom;
            b = $urandom;
            sub_i = 1'b0;
            if (!busy) begin
                q.push_back(model(a, b, 1'b0));
                acc++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        b2b = 1'b0;
        chk("b2b_count", n_done, d0 + 6);

`ifdef SERIAL_ADD_SUB_EN
        op(8'h05, 8'h07, 1'b1);
        wait_idle();
        chk("sub_0507", {cout, sum}, 9'h1FE);
        op(8'h07, 8'h05, 1'b1);
        wait_idle();
        chk("sub_0705", {cout, sum}, 9'h002);
`endif

        for (int i = 0; i < 1000; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            op(8'($urandom), 8'($urandom), s);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
